// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encodings and
// fixed AXI transfer parameters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
    localparam logic [3:0] LINE_LEN      = 4'd3;

endpackage

// File: rtl/mem_arbiter_wr.sv
// Write path of the memory arbiter: single outstanding AXI write with AW, W
// burst and B response phases.
module mem_arbiter_wr
    import mem_arbiter_pkg::*;
#(
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_wr_req,
    input  logic [31:0] data_waddr,
    input  logic [3:0]  data_awlen,
    input  logic [2:0]  data_awsize,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_wready,
    output logic        data_wlast,
    output logic        data_bvalid,
    output logic        wr_idle,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    wr_state_t  state, state_nxt;
    logic [3:0] beat_cnt;
    logic       beat_last;

    assign beat_last = (beat_cnt == awlen);
    assign wr_idle   = (state == W_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= W_IDLE;
            beat_cnt <= '0;
            awid     <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            awsize   <= '0;
        end else begin
            state <= state_nxt;
            if (state == W_IDLE && data_wr_req) begin
                awid   <= DATA_ID;
                awaddr <= data_waddr;
                awlen  <= data_awlen;
                awsize <= data_awsize;
            end
            // counter wraps to zero on the last beat so the next burst starts clean
            if (state == W_DATA && wready)
                beat_cnt <= beat_last ? '0 : beat_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        wlast       = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        bready      = 1'b0;
        data_wready = 1'b0;
        data_wlast  = 1'b0;
        data_bvalid = 1'b0;
        case (state)
            W_IDLE: if (data_wr_req) state_nxt = W_AW;
            W_AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid      = 1'b1;
                wdata       = data_wdata;
                wstrb       = data_wstrb;
                data_wready = wready;
                wlast       = beat_last;
                data_wlast  = beat_last;
                if (wready && beat_last) state_nxt = W_RESP;
            end
            W_RESP: begin
                bready      = 1'b1;
                data_bvalid = bvalid;
                if (bvalid) state_nxt = W_IDLE;
            end
            default: state_nxt = W_IDLE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data read requests onto one AXI read channel and
// forwards data writes through the write sub-module.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_rd_req,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_arlen,
    output logic        inst_rvalid,
    output logic        inst_rlast,
    output logic [31:0] inst_rdata,
    input  logic        data_rd_req,
    input  logic [31:0] data_raddr,
    input  logic [3:0]  data_arlen,
    input  logic [2:0]  data_arsize,
    output logic        data_rvalid,
    output logic        data_rlast,
    output logic [31:0] data_rdata,
    input  logic        data_wr_req,
    input  logic [31:0] data_waddr,
    input  logic [3:0]  data_awlen,
    input  logic [2:0]  data_awsize,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_wready,
    output logic        data_wlast,
    output logic        data_bvalid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_t rd_state, rd_state_nxt;
    logic      gnt_data;
    logic      last_data;
    logic      wr_idle;
    logic      data_elig;
    logic      pick_data;
    logic      grant;
    logic      beat_hit;

    // data reads wait behind any pending or active write to keep RAW ordering
    assign data_elig = data_rd_req && wr_idle && !data_wr_req;
    assign pick_data = data_elig && (!inst_rd_req || !last_data);
    assign grant     = (rd_state == R_IDLE) && (inst_rd_req || data_elig);
    assign beat_hit  = rvalid && (rid == arid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state  <= R_IDLE;
            gnt_data  <= 1'b0;
            last_data <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (grant) begin
                gnt_data  <= pick_data;
                last_data <= pick_data;
                arid      <= pick_data ? DATA_ID     : INST_ID;
                araddr    <= pick_data ? data_raddr  : inst_addr;
                arlen     <= pick_data ? data_arlen  : inst_arlen;
                arsize    <= pick_data ? data_arsize : AXI_SIZE_WORD;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_rvalid  = 1'b0;
        inst_rlast   = 1'b0;
        inst_rdata   = '0;
        data_rvalid  = 1'b0;
        data_rlast   = 1'b0;
        data_rdata   = '0;
        case (rd_state)
            R_IDLE: if (grant) rd_state_nxt = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (beat_hit) begin
                    if (gnt_data) begin
                        data_rvalid = 1'b1;
                        data_rlast  = rlast;
                        data_rdata  = rdata;
                    end else begin
                        inst_rvalid = 1'b1;
                        inst_rlast  = rlast;
                        inst_rdata  = rdata;
                    end
                    if (rlast) rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    mem_arbiter_wr #(
        .DATA_ID(DATA_ID)
    ) u_wr (
        .clk         (clk),
        .rst         (rst),
        .data_wr_req (data_wr_req),
        .data_waddr  (data_waddr),
        .data_awlen  (data_awlen),
        .data_awsize (data_awsize),
        .data_wstrb  (data_wstrb),
        .data_wdata  (data_wdata),
        .data_wready (data_wready),
        .data_wlast  (data_wlast),
        .data_bvalid (data_bvalid),
        .wr_idle     (wr_idle),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bvalid      (bvalid),
        .bready      (bready)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// read/write traffic against a transaction-level arbitration model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_rd_req, inst_rvalid, inst_rlast;
    logic [31:0] inst_addr, inst_rdata;
    logic [3:0]  inst_arlen;
    logic        data_rd_req, data_rvalid, data_rlast;
    logic [31:0] data_raddr, data_rdata;
    logic [3:0]  data_arlen;
    logic [2:0]  data_arsize;
    logic        data_wr_req, data_wready, data_wlast, data_bvalid;
    logic [31:0] data_waddr, data_wdata;
    logic [3:0]  data_awlen, data_wstrb;
    logic [2:0]  data_awsize;
    logic [3:0]  arid, arlen, rid, awid, awlen, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int b_cyc = 0;
    int ac = 0;
    int raise_cyc = 0;
    bit last_was_data = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(
        .INST_ID(4'd0),
        .DATA_ID(4'd1)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_rd_req(inst_rd_req), .inst_addr(inst_addr), .inst_arlen(inst_arlen),
        .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast), .inst_rdata(inst_rdata),
        .data_rd_req(data_rd_req), .data_raddr(data_raddr), .data_arlen(data_arlen),
        .data_arsize(data_arsize), .data_rvalid(data_rvalid), .data_rlast(data_rlast),
        .data_rdata(data_rdata), .data_wr_req(data_wr_req), .data_waddr(data_waddr),
        .data_awlen(data_awlen), .data_awsize(data_awsize), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_wready(data_wready), .data_wlast(data_wlast),
        .data_bvalid(data_bvalid), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {arvalid, rready, awvalid, wvalid, wlast, bready, inst_rvalid,
              inst_rlast, data_rvalid, data_rlast, data_wready, data_wlast, data_bvalid}, 0);
        check({tag, "_ar"}, {arid, araddr, arlen, arsize}, 0);
        check({tag, "_aw"}, {awid, awaddr, awlen, awsize}, 0);
        check({tag, "_rd"}, {inst_rdata, data_rdata}, 0);
        check({tag, "_wd"}, {wdata, wstrb}, 0);
    endtask

    // Acts as the AXI read slave for one expected transaction.
    task automatic serve_read(input bit to_data, input logic [31:0] eaddr, input logic [3:0] elen,
                              input logic [2:0] esize, input int ar_delay, input bit stray,
                              output int ar_cyc);
        logic [3:0]  eid;
        logic [31:0] d;
        int          n;
        eid = to_data ? 4'd1 : 4'd0;
        n = 0;
        @(negedge clk);
        while (!arvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ar_cyc = cyc;
        check("ar_seen", arvalid, 1);
        check("ar_fields", {arid, araddr, arlen, arsize}, {eid, eaddr, elen, esize});
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            @(negedge clk);
            check("ar_hold", {arvalid, arid, araddr}, {1'b1, eid, eaddr});
        end
        tick();
        arready = 1'b1;
        @(negedge clk);
        check("ar_hold", {arvalid, arid, araddr}, {1'b1, eid, eaddr});
        tick();
        arready = 1'b0;
        @(negedge clk);
        check("ar_drop", {arvalid, rready}, 2'b01);
        for (int b = 0; b <= elen; b++) begin
            repeat ($urandom_range(0, 1)) begin
                tick();
                rvalid = 1'b0;
                @(negedge clk);
                check("r_gap", {inst_rvalid, data_rvalid}, 2'b00);
            end
            if (stray && b == 1) begin
                tick();
                rvalid = 1'b1; rid = 4'd5; rlast = 1'b0; rdata = $urandom;
                @(negedge clk);
                check("r_stray", {inst_rvalid, data_rvalid}, 2'b00);
            end
            d = $urandom;
            tick();
            rvalid = 1'b1; rid = eid; rdata = d; rlast = (b == elen);
            @(negedge clk);
            check("r_valid", {inst_rvalid, data_rvalid}, to_data ? 2'b01 : 2'b10);
            check("r_data", to_data ? data_rdata : inst_rdata, d);
            check("r_last", to_data ? data_rlast : inst_rlast, b == elen);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        if (to_data) data_rd_req = 1'b0;
        else inst_rd_req = 1'b0;
        @(negedge clk);
        check("r_done", rready, 0);
    endtask

    // Drives one write request and acts as the AXI write slave.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [31:0] rdy_pat);
        int          n, beats, i;
        logic [31:0] d;
        logic [3:0]  s;
        logic        rdy;
        tick();
        data_wr_req = 1'b1; data_waddr = addr; data_awlen = len; data_awsize = size;
        n = 0;
        @(negedge clk);
        while (!awvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_seen", awvalid, 1);
        check("aw_fields", {awid, awaddr, awlen, awsize}, {4'd1, addr, len, size});
        repeat ($urandom_range(0, 2)) begin
            tick();
            @(negedge clk);
            check("aw_hold", {awvalid, awaddr}, {1'b1, addr});
        end
        tick();
        awready = 1'b1;
        @(negedge clk);
        check("aw_hold", {awvalid, awaddr}, {1'b1, addr});
        tick();
        awready = 1'b0;
        beats = 0;
        i = 0;
        while (beats <= len && i < 60) begin
            rdy = (i < 32) ? rdy_pat[i] : 1'b1;
            d = $urandom;
            s = 4'($urandom);
            wready = rdy; data_wdata = d; data_wstrb = s;
            @(negedge clk);
            check("w_valid", wvalid, 1);
            check("w_pass", {wdata, wstrb, data_wready}, {d, s, rdy});
            check("w_last", {wlast, data_wlast}, (beats == len) ? 2'b11 : 2'b00);
            if (rdy) beats++;
            i++;
            tick();
        end
        wready = 1'b0;
        @(negedge clk);
        check("w_resp", {wvalid, bready, data_bvalid}, 3'b010);
        repeat ($urandom_range(0, 2)) begin
            tick();
            @(negedge clk);
            check("w_resp", {wvalid, bready, data_bvalid}, 3'b010);
        end
        tick();
        bvalid = 1'b1;
        @(negedge clk);
        b_cyc = cyc;
        check("b_pulse", {bready, data_bvalid}, 2'b11);
        tick();
        bvalid = 1'b0;
        data_wr_req = 1'b0;
        @(negedge clk);
        check("b_done", {bready, data_bvalid, awvalid}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] ia;
        // reset with noisy inputs: every output must still be 0
        inst_rd_req = 1'b1; inst_addr = 32'hFFFF_FFFF; inst_arlen = 4'hF;
        data_rd_req = 1'b1; data_raddr = 32'hFFFF_FFFF; data_arlen = 4'hF; data_arsize = 3'h7;
        data_wr_req = 1'b1; data_waddr = 32'hFFFF_FFFF; data_awlen = 4'hF; data_awsize = 3'h7;
        data_wstrb = 4'hF; data_wdata = 32'hFFFF_FFFF;
        arready = 1'b1; rid = 4'd0; rdata = 32'hFFFF_FFFF; rlast = 1'b1; rvalid = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        inst_rd_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
        arready = 1'b0; rlast = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata = '0;
        tick();
        rst = 1'b1;
        tick();

        // simultaneous reads after reset: data first with slow arready and a stray beat
        tick();
        inst_addr = 32'h1FC0_0000; inst_arlen = LINE_LEN;
        data_raddr = 32'h0000_1000; data_arlen = LINE_LEN; data_arsize = 3'b001;
        inst_rd_req = 1'b1; data_rd_req = 1'b1;
        raise_cyc = cyc;
        serve_read(1'b1, 32'h0000_1000, LINE_LEN, 3'b001, 5, 1'b1, ac);
        check("ar_latency", ac, raise_cyc + 1);
        serve_read(1'b0, 32'h1FC0_0000, LINE_LEN, AXI_SIZE_WORD, 0, 1'b0, ac);
        last_was_data = 1'b0;

        // write with wready pattern 1,0,1,1,1
        do_write(32'h0000_2000, 4'd3, 3'b010, 32'h0000_001D);

        // data read blocked behind a write; inst read proceeds meanwhile
        fork
            do_write(32'h0000_3000, 4'd5, 3'b010, 32'h2492_4924);
            begin
                repeat (6) tick();
                inst_addr = 32'h1FC0_0100; inst_arlen = 4'd1;
                data_raddr = 32'h0000_3000; data_arlen = 4'd1; data_arsize = 3'b010;
                inst_rd_req = 1'b1; data_rd_req = 1'b1;
                serve_read(1'b0, 32'h1FC0_0100, 4'd1, AXI_SIZE_WORD, 0, 1'b0, ac);
                serve_read(1'b1, 32'h0000_3000, 4'd1, 3'b010, 0, 1'b0, ac);
                check("rd_after_wr", ac, b_cyc + 2);
            end
        join
        last_was_data = 1'b1;

        // randomized reads: model picks the requester not served last
        for (int t = 0; t < 14; t++) begin
            int          pat;
            bit          first_data;
            logic [31:0] ra, da;
            logic [3:0]  il, dl;
            logic [2:0]  ds;
            pat = $urandom_range(1, 3);
            ra = $urandom; da = $urandom;
            il = 4'($urandom); dl = 4'($urandom); ds = 3'($urandom);
            tick();
            inst_addr = ra; inst_arlen = il;
            data_raddr = da; data_arlen = dl; data_arsize = ds;
            inst_rd_req = pat[0]; data_rd_req = pat[1];
            first_data = (pat == 3) ? !last_was_data : (pat == 2);
            serve_read(first_data, first_data ? da : ra, first_data ? dl : il,
                       first_data ? ds : AXI_SIZE_WORD, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), ac);
            if (pat == 3)
                serve_read(!first_data, !first_data ? da : ra, !first_data ? dl : il,
                           !first_data ? ds : AXI_SIZE_WORD, $urandom_range(0, 2), 1'b0, ac);
            last_was_data = (pat == 3) ? !first_data : first_data;
        end

        // randomized writes
        for (int t = 0; t < 4; t++)
            do_write($urandom, 4'($urandom_range(0, 7)), 3'($urandom), $urandom);

        // reset on the second R beat abandons the burst
        tick();
        ia = 32'h1FC0_0040;
        inst_addr = ia; inst_arlen = LINE_LEN; inst_rd_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_ar_seen", arvalid, 1);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = $urandom; rlast = 1'b0;
        @(negedge clk);
        check("rst_beat1", inst_rvalid, 1);
        tick();
        rdata = 32'hA5A5_5A5A;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        tick();
        rst = 1'b1; rvalid = 1'b0; inst_rd_req = 1'b0;
        tick();
        inst_addr = 32'h1FC0_0080; inst_rd_req = 1'b1;
        serve_read(1'b0, 32'h1FC0_0080, LINE_LEN, AXI_SIZE_WORD, 1, 1'b0, ac);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
